// File: rtl/rst_sequencer.sv
// rst_sequencer: staggered release of reset domains plus software/external reset handling and cause capture.
// Ports: clk/rst (async active-high); ext_rst_req_i external reset level; sw_rst_req_i software reset level;
// drain_ok_i quiescence acknowledge; domain_rst_n_o per-domain active-low resets; seq_done_o all released;
// drain_req_o quiesce request; sw_rst_ack_o one-cycle software reset ack; rst_cause_o last reset cause.
module rst_sequencer #(
  parameter int NUM_DOMAINS    = 4,
  parameter int HOLD_CYCLES    = 100,
  parameter int STAGGER_CYCLES = 16,
  parameter int DRAIN_TIMEOUT  = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ext_rst_req_i,
  input  logic                   sw_rst_req_i,
  input  logic                   drain_ok_i,
  output logic [NUM_DOMAINS-1:0] domain_rst_n_o,
  output logic                   seq_done_o,
  output logic                   drain_req_o,
  output logic                   sw_rst_ack_o,
  output logic [1:0]             rst_cause_o
);
  typedef enum logic [1:0] {HOLD, RELEASE, RUN, DRAIN} state_t;
  localparam logic [15:0] HOLD_END    = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] STAGGER_END = 16'(STAGGER_CYCLES - 1);
  localparam logic [15:0] DRAIN_END   = 16'(DRAIN_TIMEOUT - 1);
  localparam logic [3:0]  LAST_IDX    = 4'(NUM_DOMAINS - 1);
  localparam logic        SINGLE      = NUM_DOMAINS == 1;
  state_t                 state_q, state_d;
  logic [15:0]            ctr_q, ctr_d;
  logic [3:0]             idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] dom_q, dom_d;
  logic                   done_q, done_d, drain_q, drain_d, ack_q, ack_d;
  logic [1:0]             cause_q, cause_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HOLD;
      ctr_q   <= '0;
      idx_q   <= '0;
      dom_q   <= '0;
      done_q  <= 1'b0;
      drain_q <= 1'b0;
      ack_q   <= 1'b0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      idx_q   <= idx_d;
      dom_q   <= dom_d;
      done_q  <= done_d;
      drain_q <= drain_d;
      ack_q   <= ack_d;
      cause_q <= cause_d;
    end
  end
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    idx_d   = idx_q;
    dom_d   = dom_q;
    done_d  = done_q;
    drain_d = drain_q;
    ack_d   = 1'b0;
    cause_d = cause_q;
    if (ext_rst_req_i) begin
      // Holding ctr at 0 keeps HOLD from expiring until the request drops.
      state_d = HOLD;
      ctr_d   = '0;
      idx_d   = '0;
      dom_d   = '0;
      done_d  = 1'b0;
      drain_d = 1'b0;
      cause_d = 2'b10;
    end else begin
      case (state_q)
        HOLD: begin
          ctr_d = ctr_q + 16'd1;
          if (ctr_q == HOLD_END) begin
            ctr_d   = '0;
            dom_d   = NUM_DOMAINS'(1);
            idx_d   = 4'd1;
            state_d = SINGLE ? RUN : RELEASE;
            done_d  = SINGLE;
          end
        end
        RELEASE: begin
          ctr_d = ctr_q + 16'd1;
          if (ctr_q == STAGGER_END) begin
            ctr_d   = '0;
            dom_d   = dom_q | (NUM_DOMAINS'(1) << idx_q);
            idx_d   = idx_q + 4'd1;
            state_d = idx_q == LAST_IDX ? RUN : RELEASE;
            done_d  = idx_q == LAST_IDX;
          end
        end
        RUN: begin
          if (sw_rst_req_i) begin
            state_d = DRAIN;
            drain_d = 1'b1;
            ctr_d   = '0;
          end
        end
        DRAIN: begin
          ctr_d = ctr_q + 16'd1;
          // drain_ok wins over a simultaneous timeout, reporting a clean reset.
          if (drain_ok_i || ctr_q == DRAIN_END) begin
            cause_d = drain_ok_i ? 2'b01 : 2'b11;
            drain_d = 1'b0;
            ack_d   = 1'b1;
            dom_d   = '0;
            done_d  = 1'b0;
            ctr_d   = '0;
            idx_d   = '0;
            state_d = HOLD;
          end
        end
        default: state_d = HOLD;
      endcase
    end
  end
  assign domain_rst_n_o = dom_q;
  assign seq_done_o     = done_q;
  assign drain_req_o    = drain_q;
  assign sw_rst_ack_o   = ack_q;
  assign rst_cause_o    = cause_q;
endmodule

// File: doc/rst_sequencer.md
# rst_sequencer

Reset sequencer that sits directly after the clock/reset generator and releases a set of subsystem reset domains (core, crypto engines, USB, I/O) in a fixed, staggered order. It also owns all later reset requests: a software reset with a drain handshake, and an external reset request. It records the cause of the most recent reset for firmware.

## Interface
Parameters:
- NUM_DOMAINS, 4, number of reset domains; range 1..8.
- HOLD_CYCLES, 100, cycles all domains are held in reset after entering HOLD; range 1..65535.
- STAGGER_CYCLES, 16, cycles between consecutive domain releases; range 1..65535.
- DRAIN_TIMEOUT, 256, maximum cycles to wait for drain_ok; range 1..65535.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ext_rst_req  in  1  external reset request, level, already synchronized to clk.
- sw_rst_req  in  1  software reset request, level; held by requester until sw_rst_ack.
- drain_ok  in  1  subsystems are quiescent; valid only while drain_req=1.
- domain_rst_n  out  NUM_DOMAINS  per-domain active-low reset, registered.
- seq_done  out  1  all domains released.
- drain_req  out  1  asks subsystems to quiesce before a software reset.
- sw_rst_ack  out  1  one-cycle pulse acknowledging the software reset.
- rst_cause  out  2  cause of last reset: 00 POR, 01 SW clean, 10 EXT, 11 SW drain timeout.

## Operation
- States: HOLD, RELEASE, RUN, DRAIN. All outputs are registered.
- The 16-bit counter ctr and the domain index idx are the only other state.
- HOLD:
  - domain_rst_n all 0; ctr increments each cycle.
  - When ctr == HOLD_CYCLES-1: ctr := 0, domain_rst_n[0] := 1, idx := 1.
  - Next state is RELEASE, or RUN with seq_done := 1 when NUM_DOMAINS = 1.
- RELEASE:
  - ctr increments each cycle.
  - When ctr == STAGGER_CYCLES-1: domain_rst_n[idx] := 1, idx++, ctr := 0.
  - On the edge that releases the last domain: seq_done := 1 and next state is RUN.
  - Released domains stay released; release order is strictly index 0 upward.
- RUN:
  - When sw_rst_req = 1: go to DRAIN, drain_req := 1, ctr := 0.
- DRAIN:
  - Domains stay released; ctr increments each cycle.
  - When drain_ok = 1: rst_cause := 01.
  - Else when ctr == DRAIN_TIMEOUT-1: rst_cause := 11.
  - On either exit: drain_req := 0, sw_rst_ack := 1 for one cycle, all domain_rst_n := 0, seq_done := 0, ctr := 0, next state HOLD.
- ext_rst_req = 1 in any state, highest priority:
  - Next edge: all domain_rst_n := 0, seq_done := 0, drain_req := 0, ctr := 0, rst_cause := 10, state := HOLD.
  - While ext_rst_req stays 1, ctr is held at 0, so HOLD does not expire.
  - If ext_rst_req arrives during DRAIN, sw_rst_ack is not pulsed. The requester keeps sw_rst_req high, and it is serviced after the next RUN entry.
- sw_rst_req is ignored in HOLD and RELEASE. It is not latched; it is the requester's level.
- After sw_rst_ack, the requester must drop sw_rst_req before the sequence reaches RUN again. If it is still high in RUN, a new software reset starts.

## Timing
- rst asserted, asynchronously: state HOLD, ctr 0, idx 0, domain_rst_n all 0, seq_done 0, drain_req 0, sw_rst_ack 0, rst_cause 00.
- Edge numbering: edge 1 is the first rising edge after rst deasserts.
- Domain k is released at edge HOLD_CYCLES + k*STAGGER_CYCLES. seq_done rises on the same edge as the last domain.
- RUN, sw_rst_req sampled 1 at edge t: drain_req = 1 from edge t.
- drain_ok sampled 1 at edge t+d: drain_req falls, sw_rst_ack pulses, and domains reset, all at edge t+d. The domains are released again HOLD_CYCLES edges later.
- Drain timeout: exit at edge t+DRAIN_TIMEOUT.
- ext_rst_req to domain_rst_n = 0: 1 edge.
- Simultaneous events:
  - ext_rst_req beats sw_rst_req and drain_ok.
  - drain_ok on the timeout cycle gives cause 01.

## Test plan
- POR, defaults, rst released: domain_rst_n goes 0001 at edge 100, 0011 at 116, 0111 at 132, 1111 at 148. seq_done = 1 at 148; rst_cause = 00.
- RUN, sw_rst_req = 1, drain_ok asserted 5 cycles later: drain_req high for 5 cycles, then sw_rst_ack pulses exactly 1 cycle. Domains go to 0000; rst_cause = 01; re-release begins 100 cycles later.
- RUN, sw_rst_req = 1, drain_ok never asserted: exit after 256 cycles with rst_cause = 11 and one sw_rst_ack pulse.
- During RELEASE (state 0011), ext_rst_req pulsed high for 3 cycles: domains go to 0000 within 1 edge. HOLD restarts after the pulse; domain 0 is released 100 edges after ext_rst_req falls; rst_cause = 10.
- sw_rst_req held high from rst release: no drain_req before seq_done. drain_req asserts on the edge after seq_done rises.
- rst asserted mid-DRAIN: all outputs return to reset values immediately, rst_cause = 00. NUM_DOMAINS = 1 variant: seq_done and domain_rst_n[0] rise together at edge 100.
